prng_share_ctrl: RTL
====================

# prng_share_ctrl

Shared pseudo-random bit source with a controller for two requesters. It owns one Fibonacci LFSR and steps it at a prescaled rate. Requests are arbitrated round-robin. For each grant it shifts OUT_BITS consecutive LFSR output bits into a word and returns that word with a one-cycle valid strobe. It sits between the main-clock domain and consumers of random data such as LED, pattern and test-stimulus blocks.

## Interface
- DIV, 600: main-clock cycles per LFSR step, range ≥1.
- LFSR_W, 4: LFSR width, range ≥2.
- TAPS, 4'b1001: feedback mask; feedback = XOR of (lfsr & TAPS).
- SEED, 4'hF: reset and fallback seed; must be non-zero.
- OUT_BITS, 8: bits per delivered word, range ≥2.
- CLK  in  1  system clock (12 MHz).
- RST  in  1  asynchronous, active-high reset.
- req  in  2  request level per requester; held high until word_valid is seen.
- seed_load  in  1  load seed_in into the LFSR.
- seed_in  in  LFSR_W  seed value.
- grant  out  2  one-hot; marks the requester currently being served.
- word_out  out  OUT_BITS  last completed word; holds its value between deliveries.
- word_valid  out  1  one-cycle strobe; word_out belongs to the granted requester.
- busy  out  1  high in RUN and DONE.
- seed_zero  out  1  sticky flag; set when an all-zero seed was replaced by SEED.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, lfsr=SEED, grant=0, word_out=0, word_valid=0, busy=0, seed_zero=0, prescaler=0, bit count=0, last-served=1, so requester 0 wins the first tie.
- LFSR step: fb = ^(lfsr & TAPS); lfsr <= {lfsr[LFSR_W-2:0], fb}; the output bit is fb. word shift register <= {word[OUT_BITS-2:0], fb}, so the first bit ends up in the MSB.
- IDLE:
  - If seed_load=1: load the LFSR and take no arbitration decision that cycle. seed_in=0 loads SEED and sets seed_zero.
  - Otherwise, if any req is high: grant the requester that was not last served when both are high, else the single requester. Clear the prescaler and bit count, update last-served, go to RUN.
- seed_load outside IDLE is ignored.
- RUN:
  - The prescaler counts 0..DIV-1.
  - At DIV-1 it wraps to 0, the LFSR steps and the bit count increments.
  - At the edge where the bit count reaches OUT_BITS, the word is copied to word_out and the state goes to DONE.
- RUN abort: if req of the granted requester drops, the next state is IDLE with grant=0 and no word_valid. word_out and the LFSR keep their current values; steps already taken are not undone.
- DONE: word_valid=1 and grant stays asserted for exactly one cycle, then IDLE with grant=0. req is not sampled for a new grant until back in IDLE.
- Lockup guard: if the lfsr equals 0 at a step, load SEED instead of stepping (unreachable with a valid SEED).
- RST asserted mid-operation: all state returns to reset values immediately, asynchronously; no word_valid.

## Timing
- Request sampled in IDLE at edge E0: grant is high from E0.
- LFSR steps occur at E0+DIV·k, for k=1..OUT_BITS.
- DONE is entered at E0+DIV·OUT_BITS; word_valid is high for the following cycle.
- Latency from request sample to word_valid is DIV·OUT_BITS cycles. Minimum spacing between back-to-back grants is DIV·OUT_BITS+2 cycles.
- A requester that keeps req high after its DONE cycle is re-arbitrated in IDLE, where the other requester wins any tie.
- All outputs are registered.

## Test plan
- Defaults with DIV=2: reset, hold req=2'b01 → grant=01 for 16 cycles, then word_valid with word_out=8'h59 and the LFSR at 4'h9.
- req=2'b11 held continuously → grants alternate 01, 10, 01. The second word continues the sequence from lfsr=4'h9 and is not a repeat.
- In IDLE, seed_load=1 with seed_in=0 → seed_zero=1 and the LFSR equals 4'hF. Then seed_in=4'h1 → the next word is generated from 4'h1.
- Drop req during RUN after 3 steps → IDLE next cycle, no word_valid, word_out unchanged. The next request continues from the LFSR state after those 3 steps.
- Assert RST mid-RUN → grant, busy and word_valid are 0 immediately. After release, req=01 reproduces word_out=8'h59.
- DIV=600 → word_valid occurs exactly 4800 cycles after the sampling edge. seed_load asserted during RUN has no effect.

Source files
------------

// File: rtl/prng_share_ctrl.sv
// Shared Fibonacci-LFSR random word source serving two requesters round-robin.
// Each grant collects OUT_BITS LFSR output bits, stepping once every DIV clocks.
module prng_share_ctrl #(
  parameter int                 DIV      = 600,
  parameter int                 LFSR_W   = 4,
  parameter logic [LFSR_W-1:0]  TAPS     = 4'b1001,
  parameter logic [LFSR_W-1:0]  SEED     = 4'hF,
  parameter int                 OUT_BITS = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          req,
  input  logic                seed_load,
  input  logic [LFSR_W-1:0]   seed_in,
  output logic [1:0]          grant,
  output logic [OUT_BITS-1:0] word_out,
  output logic                word_valid,
  output logic                busy,
  output logic                seed_zero,
  output logic [1:0]          state_dbg
);

  // Handshake: req[i] is a level held until word_valid is seen; grant is one-hot
  // from the sampling edge through the single word_valid cycle, and dropping the
  // granted req before then abandons the word without a strobe.

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(OUT_BITS + 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OUT_BITS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       presc;
  logic [CW-1:0]       bit_cnt;
  logic [LFSR_W-1:0]   lfsr;
  logic [OUT_BITS-1:0] word_sr;
  logic                last_served;
  logic                fb, req_held, step, last_step, start, pick;
  logic [1:0]          grant_nxt;
  logic                valid_nxt, busy_nxt;

  assign fb        = ^(lfsr & TAPS);
  assign req_held  = |(req & grant);
  assign start     = (state == S_IDLE) && !seed_load && (|req);
  assign step      = (state == S_RUN) && req_held && (presc == PRE_MAX);
  assign last_step = step && (bit_cnt == CNT_LAST);
  assign state_dbg = state;

  // On a tie the requester that was not served last wins.
  always_comb begin
    if (req[0] && req[1]) pick = ~last_served;
    else                  pick = req[1];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (!req_held)      state_nxt = S_IDLE;
        else if (last_step) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    grant_nxt = 2'b00;
    valid_nxt = 1'b0;
    case (state)
      S_IDLE: if (start) grant_nxt = pick ? 2'b10 : 2'b01;
      S_RUN: begin
        if (req_held) begin
          grant_nxt = grant;
          valid_nxt = last_step;
        end
      end
      default: ;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      grant       <= 2'b00;
      word_valid  <= 1'b0;
      busy        <= 1'b0;
      word_out    <= '0;
      word_sr     <= '0;
      lfsr        <= SEED;
      presc       <= '0;
      bit_cnt     <= '0;
      last_served <= 1'b1;
      seed_zero   <= 1'b0;
    end else begin
      grant      <= grant_nxt;
      word_valid <= valid_nxt;
      busy       <= busy_nxt;

      if (state == S_IDLE && seed_load) begin
        if (seed_in == '0) begin
          lfsr      <= SEED;
          seed_zero <= 1'b1;
        end else begin
          lfsr <= seed_in;
        end
      end else if (step) begin
        // An all-zero register would lock up, so it restarts from SEED.
        lfsr    <= (lfsr == '0) ? SEED : {lfsr[LFSR_W-2:0], fb};
        word_sr <= {word_sr[OUT_BITS-2:0], fb};
        if (last_step) word_out <= {word_sr[OUT_BITS-2:0], fb};
      end

      if (start) begin
        presc       <= '0;
        bit_cnt     <= '0;
        last_served <= pick;
      end else if (state == S_RUN) begin
        presc <= (presc == PRE_MAX) ? '0 : presc + 1'b1;
        if (step) bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule
